// File: rtl/vpu_fp_add_arbiter.sv
// vpu_fp_add_arbiter
// Shares one pipelined FP add/sub core between NUM_REQ requesters. Each cycle a
// round-robin arbiter grants at most one request. A fixed-latency tag pipeline
// remembers which requester owns each operation, and the core result is steered
// back to that requester. A sticky error flag is set when the core output timing
// disagrees with the tag pipeline.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid_i/ready_o   per-requester handshake (ready is the one-hot grant)
//   req_a_i/b_i/sub_i     per-requester operands and add/sub select (slice i)
//   add_tvalid_o/a/b/op   core input side (tvalid, A, B, operation)
//   add_result_tvalid_i   core result strobe
//   add_result_tdata_i    core result data
//   rsp_valid_o           one-hot result strobe to the owning requester
//   rsp_data_o            shared result data bus
//   busy_o                an operation is in flight
//   err_o                 sticky tag/result mismatch
module vpu_fp_add_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned OPERAND_WIDTH = 32,
  parameter int unsigned ADD_LATENCY   = 11
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]               req_sub_i,
  output logic                             add_tvalid_o,
  output logic [OPERAND_WIDTH-1:0]         add_a_o,
  output logic [OPERAND_WIDTH-1:0]         add_b_o,
  output logic [7:0]                       add_op_o,
  input  logic                             add_result_tvalid_i,
  input  logic [OPERAND_WIDTH-1:0]         add_result_tdata_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  output logic [OPERAND_WIDTH-1:0]         rsp_data_o,
  output logic                             busy_o,
  output logic                             err_o
);

  localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DRAIN_W = $clog2(ADD_LATENCY + 1);

  logic [ID_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [ADD_LATENCY-1:0]            tag_v_q, tag_v_d;
  logic [ADD_LATENCY-1:0][ID_W-1:0]  tag_id_q, tag_id_d;
  logic [DRAIN_W-1:0]                drain_q, drain_d;
  logic                              err_q, err_d;

  logic                              arb_en;
  logic                              gnt_any;
  logic [ID_W-1:0]                   gnt_id;
  logic                              tag_last_v;
  logic [ID_W-1:0]                   tag_last_id;

  // Issue is blocked in reset and while stale core results may still drain out.
  assign arb_en = rst_n && (drain_q == '0);

  // Round-robin search starting at rr_ptr with wrap-around.
  always_comb begin
    int unsigned idx;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (arb_en && !gnt_any && req_valid_i[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

  // Grant and core input steering.
  always_comb begin
    req_ready_o  = '0;
    add_tvalid_o = gnt_any;
    add_a_o      = '0;
    add_b_o      = '0;
    add_op_o     = 8'h00;
    if (gnt_any) begin
      req_ready_o = NUM_REQ'(1) << gnt_id;
      add_a_o     = req_a_i[32'(gnt_id)*OPERAND_WIDTH +: OPERAND_WIDTH];
      add_b_o     = req_b_i[32'(gnt_id)*OPERAND_WIDTH +: OPERAND_WIDTH];
      add_op_o    = {7'b0, req_sub_i[gnt_id]};
    end
  end

  assign tag_last_v  = tag_v_q[ADD_LATENCY-1];
  assign tag_last_id = tag_id_q[ADD_LATENCY-1];

  // Result steering; nothing is delivered during reset or for untagged results.
  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = add_result_tdata_i;
    busy_o      = rst_n && (|tag_v_q);
    err_o       = err_q;
    if (rst_n && tag_last_v && add_result_tvalid_i) begin
      rsp_valid_o = NUM_REQ'(1) << tag_last_id;
    end
  end

  // Next-state: pointer, tag shift register, drain counter, sticky error.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    tag_v_d  = '0;
    tag_id_d = '0;
    drain_d  = drain_q;
    err_d    = err_q;

    if (gnt_any) begin
      rr_ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end

    tag_v_d[0]  = gnt_any;
    tag_id_d[0] = gnt_id;
    for (int unsigned i = 1; i < ADD_LATENCY; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end

    if (drain_q != '0) begin
      drain_d = drain_q - DRAIN_W'(1);
    end else if (add_result_tvalid_i != tag_last_v) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      tag_v_q  <= '0;
      tag_id_q <= '0;
      drain_q  <= DRAIN_W'(ADD_LATENCY);
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
      drain_q  <= drain_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/vpu_fp_add_arbiter.md
Name: vpu_fp_add_arbiter

Overview:
Shares one pipelined `floating_point_add_sub` instance between NUM_REQ requesters, e.g. ADD2/ADD3/SUB/REDUCE units of the VPU.
- Performs round-robin arbitration with at most one issue per cycle.
- Tags each issued operation with the requester ID in a fixed-latency tag pipeline.
- Steers each result back to its owner.
- Checks that adder output timing matches the tag pipeline.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- OPERAND_WIDTH, 32, operand/result width (matches VPU_PKG::OPERAND_WIDTH).
- ADD_LATENCY, 11, fixed latency in cycles of the FP add/sub core from tvalid-in to result tvalid (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester operation request.
- req_ready_o  out  NUM_REQ  per-requester grant (one-hot or zero).
- req_a_i  in  NUM_REQ*OPERAND_WIDTH  operand A, requester i at slice i.
- req_b_i  in  NUM_REQ*OPERAND_WIDTH  operand B, requester i at slice i.
- req_sub_i  in  NUM_REQ  1 = A-B, 0 = A+B.
- add_tvalid_o  out  1  drives a_tvalid, b_tvalid and operation_tvalid of the core.
- add_a_o  out  OPERAND_WIDTH  core s_axis_a_tdata.
- add_b_o  out  OPERAND_WIDTH  core s_axis_b_tdata.
- add_op_o  out  8  core s_axis_operation_tdata (8'h00 add, 8'h01 sub).
- add_result_tvalid_i  in  1  core m_axis_result_tvalid.
- add_result_tdata_i  in  OPERAND_WIDTH  core m_axis_result_tdata.
- rsp_valid_o  out  NUM_REQ  one-hot result strobe to owner.
- rsp_data_o  out  OPERAND_WIDTH  result data (shared bus, qualified by rsp_valid_o).
- busy_o  out  1  any operation in flight.
- err_o  out  1  sticky tag/result mismatch flag.

Behaviour:
- Handshake: transfer occurs when req_valid_i[i] && req_ready_o[i]. No backpressure exists toward the core or from responders; a requester must accept rsp_valid_o in the cycle it is asserted.
- Arbitration is combinational. The grant goes to the first valid requester at or after rr_ptr, searching with wrap-around. req_ready_o is the one-hot grant; it is 0 when no request is valid.
- rr_ptr register: reset 0. On any grant to requester g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Core inputs are combinational from the granted slice:
  - add_tvalid_o = |grant.
  - add_a_o, add_b_o and add_op_o come from the granted requester.
  - When there is no grant they are 0.
- Tag pipeline: an ADD_LATENCY-deep shift register of {tag_v, tag_id[$clog2(NUM_REQ)-1:0]}. It shifts every cycle. Stage 0 loads {|grant, encoded grant}.
- The tag exiting the last stage is aligned with the core output in that cycle.
- Response path:
  - rsp_valid_o[tag_id] = tag_v && add_result_tvalid_i.
  - rsp_data_o = add_result_tdata_i.
  - Response latency is ADD_LATENCY cycles from the handshake.
- busy_o = OR of all tag_v.
- Mismatch: add_result_tvalid_i != tag_v in the same cycle sets err_o <= 1. No response is produced for an untagged result.
- err_o clears only on reset.
- Drain window: the core has no reset, so results issued before reset can still emerge.
  - A drain counter loads ADD_LATENCY on reset and decrements to 0.
  - While it is nonzero, mismatch checking is suppressed, untagged results are dropped, and req_ready_o is forced to 0.
- Reset values:
  - req_ready_o=0, add_tvalid_o=0, rsp_valid_o=0, busy_o=0, err_o=0.
  - All tag_v=0, rr_ptr=0, drain=ADD_LATENCY.
- Reset mid-operation: all in-flight tags are discarded and their results are never delivered. Requesters must re-issue.
- Simultaneous issue and completion in one cycle are independent: a full issue rate of 1 per cycle is sustained indefinitely.

Test Plan:
- After reset and ADD_LATENCY drain cycles, requester 0 issues 0x3F800000 + 0x40000000 -> req_ready_o=4'b0001 in the handshake cycle. rsp_valid_o=4'b0001 and rsp_data_o=0x40400000 (3.0) exactly 11 cycles later.
- All 4 requesters hold valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3 in order. Responses return in the same order, 11 cycles later, one per cycle.
- Requester 2 issues sub 0x40400000 - 0x3F800000 -> add_op_o=8'h01 in the grant cycle. Response on rsp_valid_o[2] with data 0x40000000.
- Only requesters 1 and 3 valid, with rr_ptr=2 -> grant 3 first, then 1, then 3. rr_ptr goes 0 -> 2 -> 0.
- Force add_result_tvalid_i=1 with no tag after the drain -> err_o=1 next cycle and stays 1. No rsp_valid_o. Then assert rst_n=0 for one cycle -> err_o=0.
- Issue 3 ops, then assert reset 5 cycles in while the core still emits results -> no rsp_valid_o, err_o stays 0 through the drain, req_ready_o=0 for 11 cycles after reset.
